// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    DONE,
    ERROR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_WIDTH     = 32;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - little-endian byte-to-word assembler
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]            idx_q;
  logic [WORD_WIDTH-9:0] low_q;

  // The last byte is not stored: the word is presented combinationally with it on top,
  // so the consumer can register the finished word on the same edge the byte arrives.
  assign word_valid = byte_valid && (idx_q == LAST_IDX);
  assign word       = {byte_data, low_q};

  // Byte index and storage for the three lower bytes of the word being assembled.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      idx_q <= '0;
      low_q <= '0;
    end else if (byte_valid) begin
      idx_q <= idx_q + 2'd1;
      case (idx_q)
        2'd0:    low_q[7:0]   <= byte_data;
        2'd1:    low_q[15:8]  <= byte_data;
        2'd2:    low_q[23:16] <= byte_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream image loader writing packed words into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [WORD_WIDTH-1:0] imem_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam logic [31:0] DEPTH = 32'(1) << ADDR_WIDTH;

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH:0]   wcnt_q;
  logic [31:0]           len_q;
  logic [31:0]           wcnt_next;
  logic                  start_ok;
  logic                  pack_valid;
  logic [WORD_WIDTH-1:0] pk_word;
  logic                  pk_word_valid;

  // start only re-arms when no frame is in flight; LEN/DATA ignore it.
  assign start_ok   = start && (state_q inside {IDLE, DONE, ERROR});
  // Bytes sunk in ERROR never reach the packer.
  assign pack_valid = in_valid && (state_q inside {LEN, DATA});
  assign wcnt_next  = 32'(wcnt_q) + 32'd1;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and state-derived status outputs.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    load_done  = 1'b0;
    load_error = 1'b0;
    core_hold  = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        in_ready = 1'b1;
        if (pk_word_valid) begin
          if (pk_word == 32'd0)     state_d = DONE;
          else if (pk_word > DEPTH) state_d = ERROR;
          else                      state_d = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (pk_word_valid && (wcnt_next == len_q)) state_d = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        core_hold = 1'b0;
        if (start) state_d = LEN;
      end
      ERROR: begin
        in_ready   = 1'b1;
        load_error = 1'b1;
        if (start) state_d = LEN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Length capture, word counter and the registered memory write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wcnt_q     <= '0;
      len_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (start_ok) begin
        wcnt_q <= '0;
      end
      if (state_q == LEN && pk_word_valid) begin
        len_q <= pk_word;
      end
      if (state_q == DATA && pk_word_valid) begin
        imem_we    <= 1'b1;
        imem_addr  <= wcnt_q[ADDR_WIDTH-1:0];
        imem_wdata <= pk_word;
        wcnt_q     <= wcnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_error;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          gaps     = 1'b0;
  wr_t         exp_q[$];
  logic [31:0] mem_model [DEPTH];
  logic [31:0] words[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model: every write the DUT issues must match the next expected word.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'(imem_addr), 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), e.addr);
        chk("wr_data", imem_wdata, e.data);
        chk("wr_latency", 32'(cyc), 32'(e.due));
      end
      mem_model[imem_addr] = imem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (gaps) begin
      for (int g = 0; g < 8 && $urandom_range(1) == 0; g++) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
  endtask

  task automatic expect_write(input int idx, input logic [31:0] w);
    exp_q.push_back('{addr: idx, data: w, due: cyc});
  endtask

  task automatic send_data(input int idx, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    expect_write(idx, w);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_frame();
    send_len(32'(words.size()));
    foreach (words[i]) send_data(i, words[i]);
  endtask

  logic [31:0] w0;
  int          n;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'd0;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;

    // 1) reset values
    tick(); tick();
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_error", 32'(load_error), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    reset = 1'b1;
    tick();

    // 2) two-word image at full rate
    pulse_start();
    chk("len_in_ready", 32'(in_ready), 32'd1);
    chk("len_core_hold", 32'(core_hold), 32'd1);
    words = '{32'h0010_0513, 32'h0020_0593};
    load_frame();
    chk("t2_done", 32'(load_done), 32'd1);
    chk("t2_core_hold", 32'(core_hold), 32'd0);
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    send_byte(8'hee);
    tick();
    chk("t2_pending", 32'(exp_q.size()), 32'd0);
    chk("t2_mem0", mem_model[0], 32'h0010_0513);
    chk("t2_mem1", mem_model[1], 32'h0020_0593);

    // 3) empty image goes straight to DONE
    pulse_start();
    chk("t3_core_hold", 32'(core_hold), 32'd1);
    chk("t3_done_clr", 32'(load_done), 32'd0);
    send_len(32'd0);
    chk("t3_done", 32'(load_done), 32'd1);
    chk("t3_core_hold_rel", 32'(core_hold), 32'd0);
    tick(); tick();

    // 4) oversize length, sink bytes, recover, then exact-depth image
    pulse_start();
    send_len(32'(DEPTH + 1));
    chk("t4_error", 32'(load_error), 32'd1);
    chk("t4_core_hold", 32'(core_hold), 32'd1);
    chk("t4_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    chk("t4_error_hold", 32'(load_error), 32'd1);
    pulse_start();
    chk("t4_recover_err", 32'(load_error), 32'd0);
    chk("t4_recover_rdy", 32'(in_ready), 32'd1);
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
    load_frame();
    chk("t4_full_done", 32'(load_done), 32'd1);
    tick();
    chk("t4_full_first", mem_model[0], words[0]);
    chk("t4_full_last", mem_model[DEPTH-1], words[DEPTH-1]);

    // 5) same image with random gaps, start mid-DATA ignored, then random frames
    gaps = 1'b1;
    pulse_start();
    send_len(32'd2);
    send_byte(8'h13);
    send_byte(8'h05);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_still_data", 32'(in_ready), 32'd1);
    send_byte(8'h10);
    send_byte(8'h00);
    expect_write(0, 32'h0010_0513);
    send_data(1, 32'h0020_0593);
    chk("t5_done", 32'(load_done), 32'd1);
    for (int f = 0; f < 4; f++) begin
      pulse_start();
      n = $urandom_range(6, 1);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      load_frame();
      chk("t5_rand_done", 32'(load_done), 32'd1);
    end
    tick();

    // 6) reset after 5 of 8 data bytes
    gaps = 1'b0;
    pulse_start();
    send_len(32'd2);
    w0 = $urandom;
    send_data(0, w0);
    send_byte(8'h5a);
    reset = 1'b0;
    tick();
    chk("t6_core_hold", 32'(core_hold), 32'd1);
    chk("t6_in_ready", 32'(in_ready), 32'd0);
    chk("t6_we", 32'(imem_we), 32'd0);
    chk("t6_done", 32'(load_done), 32'd0);
    chk("t6_addr", 32'(imem_addr), 32'd0);
    chk("t6_wdata", imem_wdata, 32'd0);
    reset = 1'b1;
    tick();
    chk("t6_mem0_kept", mem_model[0], w0);
    chk("t6_pending", 32'(exp_q.size()), 32'd0);
    pulse_start();
    words = '{32'hcafe_f00d};
    load_frame();
    chk("t6_reload_done", 32'(load_done), 32'd1);

    tick(); tick();
    chk("end_pending", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
